wordle_guess_scorer: RTL and testbench



---
 rtl/wordle_pkg.sv | 29 ++
 rtl/wordle_guess_scorer.sv | 135 +++++++++++++
 tb/tb_wordle_guess_scorer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wordle_pkg.sv
// Shared Wordle definitions: colour codes, word geometry, scorer states and
// letter extraction from a packed word.
package wordle_pkg;

  localparam int WORD_LEN = 5;
  localparam int LETTER_W = 8;

  localparam logic [2:0] CLR_GREEN  = 3'b010;
  localparam logic [2:0] CLR_YELLOW = 3'b110;
  localparam logic [2:0] CLR_WHITE  = 3'b111;
  localparam logic [LETTER_W-1:0] BLANK = 8'h20;

  // One-hot to line up with the game FSM encoding
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GREEN  = 4'b0010,
    ST_YELLOW = 4'b0100,
    ST_DONE   = 4'b1000
  } state_t;

  // Letter 0 lives in the MSBs of the packed word
  function automatic logic [LETTER_W-1:0] get_letter(
    input logic [WORD_LEN*LETTER_W-1:0] word,
    input logic [2:0]                   idx
  );
    return word[(WORD_LEN-1-int'(idx))*LETTER_W +: LETTER_W];
  endfunction

endpackage

// File: rtl/wordle_guess_scorer.sv
// Multi-cycle Wordle scorer: one green pass then an i/j yellow pass with
// per-target-letter consumption, result published on a one-cycle done pulse.
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int WORD_LEN = wordle_pkg::WORD_LEN,
  parameter int LETTER_W = wordle_pkg::LETTER_W
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WORD_LEN*LETTER_W-1:0] guess,
  input  logic [WORD_LEN*LETTER_W-1:0] target,
  output logic                         busy,
  output logic                         done,
  output logic [3*WORD_LEN-1:0]        colors,
  output logic                         win
);

  localparam int         WW   = WORD_LEN*LETTER_W;
  localparam logic [2:0] LAST = 3'(WORD_LEN-1);

  state_t                     state, state_nxt;
  logic [2:0]                 i_q, j_q, i_nxt, j_nxt;
  logic [WW-1:0]              g_q, t_q;
  logic [WORD_LEN-1:0][2:0]   work_q;
  logic [WORD_LEN-1:0]        used_q;

  logic [LETTER_W-1:0]        g_i, t_i, t_j;
  logic                       green_hit, yellow_hit;
  logic [3*WORD_LEN-1:0]      work_flat;
  logic                       all_green;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= ST_IDLE;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      state <= state_nxt;
      i_q   <= i_nxt;
      j_q   <= j_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    unique case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_GREEN;
        i_nxt     = '0;
        j_nxt     = '0;
      end
      ST_GREEN: if (i_q == LAST) begin
        state_nxt = ST_YELLOW;
        i_nxt     = '0;
        j_nxt     = '0;
      end else begin
        i_nxt = i_q + 3'd1;
      end
      ST_YELLOW: if (j_q == LAST) begin
        j_nxt = '0;
        if (i_q == LAST) begin
          state_nxt = ST_DONE;
          i_nxt     = '0;
        end else begin
          i_nxt = i_q + 3'd1;
        end
      end else begin
        j_nxt = j_q + 3'd1;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A blank guess letter never scores, even against a blank in the target
  always_comb begin
    g_i        = get_letter(g_q, i_q);
    t_i        = get_letter(t_q, i_q);
    t_j        = get_letter(t_q, j_q);
    green_hit  = (state == ST_GREEN) && (g_i != BLANK) && (g_i == t_i);
    yellow_hit = (state == ST_YELLOW) && (work_q[i_q] == CLR_WHITE) &&
                 !used_q[j_q] && (g_i != BLANK) && (g_i == t_j);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      g_q    <= '0;
      t_q    <= '0;
      work_q <= {WORD_LEN{CLR_WHITE}};
      used_q <= '0;
    end else if (state == ST_IDLE && start) begin
      g_q    <= guess;
      t_q    <= target;
      work_q <= {WORD_LEN{CLR_WHITE}};
      used_q <= '0;
    end else if (green_hit) begin
      work_q[i_q] <= CLR_GREEN;
      used_q[i_q] <= 1'b1;
    end else if (yellow_hit) begin
      work_q[i_q] <= CLR_YELLOW;
      used_q[j_q] <= 1'b1;
    end
  end

  always_comb begin
    work_flat = '0;
    all_green = 1'b1;
    for (int k = 0; k < WORD_LEN; k++) begin
      work_flat[(WORD_LEN-1-k)*3 +: 3] = work_q[k];
      if (work_q[k] != CLR_GREEN) all_green = 1'b0;
    end
  end

  // Outputs are registered so the scoring passes never leak onto colors/win
  always_ff @(posedge Clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      colors <= {WORD_LEN{CLR_WHITE}};
      win    <= 1'b0;
    end else begin
      busy <= (state == ST_GREEN) || (state == ST_YELLOW);
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        colors <= work_flat;
        win    <= all_green;
      end
    end
  end

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Self-checking bench for wordle_guess_scorer: vector table plus a
// scoreboard of expected results checked on each done pulse.
module tb_wordle_guess_scorer;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [39:0] guess = '0;
  logic [39:0] target = '0;
  logic        busy, done, win;
  logic [14:0] colors;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [39:0] g;
    logic [39:0] t;
    logic [14:0] c;
    logic        w;
  } vec_t;

  typedef struct {
    logic [14:0] c;
    logic        w;
    int          due;
  } exp_t;

  vec_t vecs[5];
  exp_t sbq[$];

  wordle_guess_scorer dut (
    .Clk(Clk), .reset(reset), .start(start), .guess(guess), .target(target),
    .busy(busy), .done(done), .colors(colors), .win(win)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller is at a negedge; start is sampled on the next posedge
  task automatic issue(input logic [39:0] g, input logic [39:0] t,
                       input logic [14:0] c, input logic w, input bit expect_done);
    guess = g;
    target = t;
    start = 1'b1;
    if (expect_done) sbq.push_back('{c: c, w: w, due: cyc + 1 + 31});
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sbq.size() != 0 && n < lim) begin
      @(negedge Clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  always @(negedge Clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("colors", 32'(colors), 32'(e.c));
        chk("win", 32'(win), 32'(e.w));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"CRANE", "CRANE", 15'b010_010_010_010_010, 1'b1};
    vecs[1] = '{"NACER", "CRANE", 15'b110_110_110_110_110, 1'b0};
    vecs[2] = '{"BOBBY", "ABBEY", 15'b110_111_010_111_010, 1'b0};
    vecs[3] = '{"     ", "A B C", 15'b111_111_111_111_111, 1'b0};
    vecs[4] = '{"SPEED", "ABIDE", 15'b111_111_110_111_110, 1'b0};

    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_colors", 32'(colors), 32'h7FFF);
    chk("rst_win", 32'(win), 32'd0);
    reset = 1'b0;
    @(negedge Clk);

    for (int v = 0; v < 5; v++) begin
      issue(vecs[v].g, vecs[v].t, vecs[v].c, vecs[v].w, 1'b1);
      drain(40);
      @(negedge Clk);
    end

    // busy window around a single evaluation
    issue("CRANE", "CRANE", 15'b010_010_010_010_010, 1'b1, 1'b1);
    @(negedge Clk);
    chk("busy_p1", 32'(busy), 32'd1);
    repeat (29) @(negedge Clk);
    chk("busy_p30", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("busy_p31", 32'(busy), 32'd0);
    chk("done_p31", 32'(done), 32'd1);
    drain(5);
    @(negedge Clk);

    // start while busy is dropped; back-to-back start right after done
    issue("BOBBY", "ABBEY", 15'b110_111_010_111_010, 1'b0, 1'b1);
    repeat (5) @(negedge Clk);
    issue("CRANE", "CRANE", 15'b0, 1'b0, 1'b0);
    repeat (25) @(negedge Clk);
    chk("ignored_done_p31", 32'(done), 32'd1);
    issue("NACER", "CRANE", 15'b110_110_110_110_110, 1'b0, 1'b1);
    drain(40);
    chk("ignored_busy_idle", 32'(busy), 32'd0);
    @(negedge Clk);

    // reset mid-evaluation: no done, outputs back to reset values
    issue("CRANE", "CRANE", 15'b0, 1'b0, 1'b0);
    repeat (10) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_colors", 32'(colors), 32'h7FFF);
    chk("midrst_win", 32'(win), 32'd0);
    repeat (30) @(negedge Clk);
    chk("midrst_colors_hold", 32'(colors), 32'h7FFF);
    issue("SPEED", "ABIDE", 15'b111_111_110_111_110, 1'b0, 1'b1);
    drain(40);

    repeat (40) @(negedge Clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
